// File: rtl/ps2_kbd_dev_io.sv
// PS/2 keyboard receiver: synchronises the pins, deserialises 11-bit device frames,
// checks start/parity/stop and buffers good scan codes in a FIFO read over MIO_BUS.
module ps2_kbd_dev_io #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        rd_en,
  input  logic        clr_err,
  output logic [31:0] data_out,
  output logic        irq
);

  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // [0],[1] synchroniser stages, [2] previous synchronised value for edge detect
  logic [2:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       fall;
  logic       sdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

  assign fall  = clk_sync_q[2] & ~clk_sync_q[1];
  assign sdata = data_sync_q[1];

  state_t         state_q;
  logic [2:0]     bit_cnt_q;
  logic [7:0]     shift_q;
  logic           parity_q;
  logic [WDW-1:0] wd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      wd_q      <= '0;
    end else if (state_q == S_IDLE) begin
      wd_q <= '0;
      if (fall && !sdata) begin
        state_q   <= S_DATA;
        bit_cnt_q <= '0;
      end
    end else if (fall) begin
      wd_q <= '0;
      unique case (state_q)
        S_DATA: begin
          shift_q   <= {sdata, shift_q[7:1]};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
        end
        S_PARITY: begin
          parity_q <= sdata;
          state_q  <= S_STOP;
        end
        default: state_q <= S_IDLE;
      endcase
    end else if (wd_q == WD_MAX) begin
      state_q <= S_IDLE;
      wd_q    <= '0;
    end else begin
      wd_q <= wd_q + WDW'(1);
    end
  end

  // Frame verdict is decoded in the stop-bit fall cycle so the push lands on that edge.
  logic stop_cycle;
  logic parity_ok;
  logic push;
  logic par_set;
  logic frm_set;

  always_comb begin
    stop_cycle = (state_q == S_STOP) && fall;
    parity_ok  = ^{shift_q, parity_q};
    push       = stop_cycle && sdata && parity_ok;
    par_set    = stop_cycle && sdata && !parity_ok;
    frm_set    = stop_cycle && !sdata;
  end

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic          ovf_set;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  always_comb begin
    pop     = rd_en && (count_q != '0);
    full    = (count_q == FULL_CNT);
    push_ok = push && (!full || pop);
    ovf_set = push && full && !pop;
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  logic ovf_q;
  logic par_q;
  logic frm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      par_q <= 1'b0;
      frm_q <= 1'b0;
    end else begin
      ovf_q <= ovf_set | (ovf_q & ~clr_err);
      par_q <= par_set | (par_q & ~clr_err);
      frm_q <= frm_set | (frm_q & ~clr_err);
    end
  end

  logic       ready;
  logic [3:0] cnt_sat;
  logic [7:0] head;

  always_comb begin
    ready   = (count_q != '0);
    cnt_sat = (int'(count_q) > 15) ? 4'hF : 4'(count_q);
    head    = ready ? mem_q[rd_ptr_q] : 8'h00;
  end

  assign data_out = {ready, ovf_q, par_q, frm_q, 16'h0000, cnt_sat, head};
  assign irq      = ready;

endmodule
